video_status_rd: RTL and testbench

// Z80 read-back side of the video port bank; the port latches carry only the write direction.

---
 rtl/video_status_rd.sv | 119 +++++++++++
 tb/tb_video_status_rd.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/video_status_rd.sv
// video_status_rd: Z80 read-back of the video port bank.
//   Returns one registered byte per read strobe (1-cycle latency, dout_vld pulse).
//   Holds an atomic raster snapshot, an optional frame counter, sticky
//   read-to-clear interrupt flags and a one-shot power-up flag.
// Ports:
//   clk, res (sync, active-high)
//   status_rd, vcntl_rd, vcnth_rd, hcnt_rd, frcnt_rd, intfl_rd : read strobes
//   int_start, line_int, dma_end : event pulses
//   vcnt[8:0], hcnt[7:0] : live raster position
//   dout[7:0], dout_vld : read data and valid pulse
// Config: define VSTAT_FRCNT_EN to build the frame counter; otherwise
//   frcnt_rd returns 8'hFF.
module video_status_rd #(
  parameter logic [2:0] VDAC_ID    = 3'd2,
  parameter logic       PWRUP_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       status_rd,
  input  logic       vcntl_rd,
  input  logic       vcnth_rd,
  input  logic       hcnt_rd,
  input  logic       frcnt_rd,
  input  logic       intfl_rd,
  input  logic       int_start,
  input  logic       line_int,
  input  logic       dma_end,
  input  logic [8:0] vcnt,
  input  logic [7:0] hcnt,
  output logic [7:0] dout,
  output logic       dout_vld
);

  logic       pwr;
  logic       snap_v8;
  logic [7:0] snap_h;
  logic [2:0] flags;
  logic [2:0] events;

  logic       sel_status, sel_vcntl, sel_vcnth, sel_hcnt, sel_frcnt, sel_intfl;
  logic       any_rd;
  logic [7:0] rd_data;
  logic [2:0] flags_nxt;

`ifdef VSTAT_FRCNT_EN
  logic [7:0] frcnt;
`endif

  // Fixed priority: only the winning strobe produces data or side effects.
  always_comb begin
    sel_status = status_rd;
    sel_vcntl  = vcntl_rd & ~status_rd;
    sel_vcnth  = vcnth_rd & ~status_rd & ~vcntl_rd;
    sel_hcnt   = hcnt_rd  & ~status_rd & ~vcntl_rd & ~vcnth_rd;
    sel_frcnt  = frcnt_rd & ~status_rd & ~vcntl_rd & ~vcnth_rd & ~hcnt_rd;
    sel_intfl  = intfl_rd & ~status_rd & ~vcntl_rd & ~vcnth_rd & ~hcnt_rd & ~frcnt_rd;
    any_rd     = status_rd | vcntl_rd | vcnth_rd | hcnt_rd | frcnt_rd | intfl_rd;
  end

  always_comb begin
    rd_data = '1;
    if (sel_status)
      rd_data = {1'b0, pwr, 2'b00, VDAC_ID, 1'b0};
    else if (sel_vcntl)
      rd_data = vcnt[7:0];
    else if (sel_vcnth)
      rd_data = {7'b0, snap_v8};
    else if (sel_hcnt)
      rd_data = snap_h;
    else if (sel_frcnt) begin
`ifdef VSTAT_FRCNT_EN
      rd_data = frcnt;
`else
      rd_data = '1;
`endif
    end
    else if (sel_intfl)
      rd_data = {5'b0, flags};
  end

  // A read clears exactly the bits it returned as 1; events arriving in the
  // same cycle are OR-ed in afterwards so set wins over clear.
  always_comb begin
    events    = {dma_end, line_int, int_start};
    flags_nxt = sel_intfl ? events : (flags | events);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      dout     <= '1;
      dout_vld <= 1'b0;
      snap_v8  <= 1'b0;
      snap_h   <= '0;
      flags    <= '0;
      pwr      <= PWRUP_INIT;
    end else begin
      dout_vld <= any_rd;
      if (any_rd)
        dout <= rd_data;
      if (sel_status)
        pwr <= 1'b0;
      if (sel_vcntl) begin
        snap_v8 <= vcnt[8];
        snap_h  <= hcnt;
      end
      flags <= flags_nxt;
    end
  end

`ifdef VSTAT_FRCNT_EN
  always_ff @(posedge clk) begin
    if (res)
      frcnt <= '0;
    else if (int_start)
      frcnt <= frcnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_video_status_rd.sv
module tb_video_status_rd;

  logic       clk = 1'b0;
  logic       res;
  logic       status_rd, vcntl_rd, vcnth_rd, hcnt_rd, frcnt_rd, intfl_rd;
  logic       int_start, line_int, dma_end;
  logic [8:0] vcnt;
  logic [7:0] hcnt;
  logic [7:0] dout;
  logic       dout_vld;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // strobe mask bits
  localparam logic [5:0] M_STATUS = 6'b100000;
  localparam logic [5:0] M_VCNTL  = 6'b010000;
  localparam logic [5:0] M_VCNTH  = 6'b001000;
  localparam logic [5:0] M_HCNT   = 6'b000100;
  localparam logic [5:0] M_FRCNT  = 6'b000010;
  localparam logic [5:0] M_INTFL  = 6'b000001;

  video_status_rd #(.VDAC_ID(3'd2), .PWRUP_INIT(1'b1)) dut (
    .clk(clk), .res(res),
    .status_rd(status_rd), .vcntl_rd(vcntl_rd), .vcnth_rd(vcnth_rd),
    .hcnt_rd(hcnt_rd), .frcnt_rd(frcnt_rd), .intfl_rd(intfl_rd),
    .int_start(int_start), .line_int(line_int), .dma_end(dma_end),
    .vcnt(vcnt), .hcnt(hcnt), .dout(dout), .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Events may be raised by the caller beforehand; they are dropped with the strobes.
  task automatic do_read(input string tag, input logic [5:0] m, input logic [7:0] exp);
    {status_rd, vcntl_rd, vcnth_rd, hcnt_rd, frcnt_rd, intfl_rd} = m;
    @(posedge clk); #1;
    {status_rd, vcntl_rd, vcnth_rd, hcnt_rd, frcnt_rd, intfl_rd} = '0;
    int_start = 1'b0; line_int = 1'b0; dma_end = 1'b0;
    check({tag, "_vld"}, {7'b0, dout_vld}, 8'h01);
    check(tag, dout, exp);
  endtask

  task automatic idle_hold(input string tag, input logic [7:0] exp);
    @(posedge clk); #1;
    check({tag, "_vldlow"}, {7'b0, dout_vld}, 8'h00);
    check({tag, "_hold"}, dout, exp);
  endtask

  task automatic pulse(input logic [2:0] ev);
    {dma_end, line_int, int_start} = ev;
    @(posedge clk); #1;
    {dma_end, line_int, int_start} = '0;
  endtask

  initial begin
    res = 1'b1;
    {status_rd, vcntl_rd, vcnth_rd, hcnt_rd, frcnt_rd, intfl_rd} = '0;
    {int_start, line_int, dma_end} = '0;
    vcnt = 9'h1AB; hcnt = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'hFF);
    check("rst_vld", {7'b0, dout_vld}, 8'h00);
    res = 1'b0;
    idle_hold("rst_idle", 8'hFF);

    // snapshot registers read 0 before any vcntl_rd, regardless of live counters
    do_read("vcnth_nosnap", M_VCNTH, 8'h00);
    do_read("hcnt_nosnap", M_HCNT, 8'h00);

    // power-up flag, one-shot
    do_read("status1", M_STATUS, 8'h44);
    idle_hold("status1", 8'h44);
    do_read("status2", M_STATUS, 8'h04);

    // atomic raster snapshot
    vcnt = 9'h12C; hcnt = 8'h5A;
    do_read("vcntl", M_VCNTL, 8'h2C);
    vcnt = 9'h000; hcnt = 8'h10;
    do_read("vcnth_snap", M_VCNTH, 8'h01);
    do_read("hcnt_snap", M_HCNT, 8'h5A);

    // frame counter: 257 events wrap to 1
    int_start = 1'b1;
    repeat (257) @(posedge clk);
    #1 int_start = 1'b0;
`ifdef VSTAT_FRCNT_EN
    do_read("frcnt_wrap", M_FRCNT, 8'h01);
`else
    do_read("frcnt_off", M_FRCNT, 8'hFF);
`endif
    repeat (4) pulse(3'b001);
    int_start = 1'b1;
`ifdef VSTAT_FRCNT_EN
    do_read("frcnt_same_cyc", M_FRCNT, 8'h05);
    do_read("frcnt_after", M_FRCNT, 8'h06);
`else
    do_read("frcnt_off_same", M_FRCNT, 8'hFF);
    do_read("frcnt_off2", M_FRCNT, 8'hFF);
`endif

    // frame flag left set by the events above
    do_read("intfl_frame", M_INTFL, 8'h01);
    do_read("intfl_clr0", M_INTFL, 8'h00);

    // line + dma flags, read-to-clear
    pulse(3'b010);
    pulse(3'b100);
    do_read("intfl_ld", M_INTFL, 8'h06);
    do_read("intfl_clr1", M_INTFL, 8'h00);

    // event coincident with the clearing read is kept
    int_start = 1'b1;
    do_read("intfl_setwin", M_INTFL, 8'h00);
    do_read("intfl_kept", M_INTFL, 8'h01);

    // multi-strobe: status wins, flags untouched
    pulse(3'b001);
    do_read("multi_status", M_STATUS | M_INTFL, 8'h04);
    do_read("multi_flags", M_INTFL, 8'h01);

    // multi-strobe: vcntl wins over hcnt, snapshot still taken
    vcnt = 9'h0AB; hcnt = 8'h77;
    do_read("multi_vcntl", M_VCNTL | M_HCNT, 8'hAB);
    do_read("multi_snap_v8", M_VCNTH, 8'h00);
    do_read("multi_snap_h", M_HCNT, 8'h77);

    // reset during a read suppresses valid and restores pwr
    pulse(3'b010);
    res = 1'b1; status_rd = 1'b1;
    @(posedge clk); #1;
    status_rd = 1'b0; res = 1'b0;
    check("res_rd_vld", {7'b0, dout_vld}, 8'h00);
    check("res_rd_dout", dout, 8'hFF);
    do_read("res_status", M_STATUS, 8'h44);
    do_read("res_flags", M_INTFL, 8'h00);
    do_read("res_snap_h", M_HCNT, 8'h00);
`ifdef VSTAT_FRCNT_EN
    do_read("res_frcnt", M_FRCNT, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
